serial_deserializer: RTL and testbench
======================================

# serial_deserializer

Upstream stage of the byte queue. Collects a serial bit stream (one bit per `write_in` rising edge, LSB first) into a byte. On an `enqueue_in` rising edge it hands the completed byte to the queue over a valid/ack handshake. It reports readiness on `status_out` and flags protocol misuse on a one-cycle `drop_out` pulse.

## Interface
- `DATA_W`, default 8: bits per word. The bit counter is `$clog2(DATA_W)+1` bits wide.
- `clock_1MHz`, input, 1 bit: single clock; all logic is rising-edge.
- `rst`, input, 1 bit: reset, synchronous, active-high.
- `data_in`, input, 1 bit: serial data bit, sampled on a `write_in` rising edge.
- `write_in`, input, 1 bit: level strobe held for multiple cycles; only its rising edge acts.
- `enqueue_in`, input, 1 bit: level strobe; only its rising edge acts.
- `data_ack_in`, input, 1 bit: queue accepts `data_out` on any cycle where it is high while `data_valid_out` is high.
- `data_out`, output, `DATA_W` bits: assembled word.
- `data_valid_out`, output, 1 bit: word offered to the queue.
- `status_out`, output, 1 bit: high when bits are accepted (state COLLECT).
- `drop_out`, output, 1 bit: one-cycle pulse when an ignored edge is detected.

## Operation
- FSM states: COLLECT → FULL → HANDOFF → COLLECT.
- COLLECT:
  - On a write edge, `shreg[cnt] <= data_in` and `cnt <= cnt+1`.
  - When `cnt` reaches `DATA_W`, go to FULL and copy `shreg` to `data_out`.
  - An enqueue edge is ignored and pulses `drop_out`. A partial word is kept.
- FULL:
  - An enqueue edge moves to HANDOFF.
  - A write edge is ignored and pulses `drop_out`. The bit is lost.
- HANDOFF:
  - `data_valid_out=1` and `data_out` is stable.
  - When `data_ack_in` is sampled high, go to COLLECT and clear `cnt` and `shreg`.
  - A write or enqueue edge is ignored and pulses `drop_out`.
- `data_out` holds the last completed word until the next word completes.
- Write and enqueue edges in the same cycle: only the edge legal for the current state acts. The other pulses `drop_out`; a single pulse covers both.
- Edge detection: `rise = in & ~prev`, where `prev` is a register.
  - `prev` registers reset to 1, so an input already high at reset release produces no edge.
- Reset values:
  - state COLLECT, `cnt=0`, `shreg=0`.
  - `data_out=0`, `data_valid_out=0`, `status_out=1`, `drop_out=0`.
- Reset mid-word or mid-handoff discards all state. Any partial or unacked word is lost.

## Timing
- Without the synchronizer: on the first edge where `write_in` is sampled high, `data_in` from that same edge is captured. It is visible in `shreg` one cycle later.
- Completion: the `DATA_W`th write edge at cycle k gives FULL and `data_out` updated at k+1, and `status_out=0` at k+1.
- Enqueue edge sampled at cycle k gives `data_valid_out=1` at k+1.
- Ack sampled at cycle k gives `data_valid_out=0` and `status_out=1` at k+1. The minimum handoff is 1 cycle if ack is already high.
- `drop_out` goes high the cycle after the offending edge is sampled, for exactly 1 cycle.
- There is no minimum strobe width beyond 1 cycle high and 1 cycle low between edges.

## Configuration
- `SERIAL_DESER_SYNC_EN`
  - Defined: `data_in`, `write_in` and `enqueue_in` each pass through a 2-flop synchronizer before edge detection.
    - All latencies above grow by 2 cycles.
    - `data_in` is delayed identically, so bit alignment with `write_in` is preserved.
    - Synchronizer flops reset to 0. The edge `prev` flops reset to 1, as above.
  - Undefined: inputs go directly to the edge detectors, with the latencies given above.

## Structure
- Package `serial_deser_pkg`:
  - `typedef enum logic [1:0] {COLLECT, FULL, HANDOFF} deser_state_t`
  - `localparam DATA_W_DEFAULT = 8`
- Sub-module `edge_rise`:
  - Ports `clock_1MHz`, `rst`, `in`, `rise`; internal `prev` resets to 1.
  - Instantiated for `write_in` and for `enqueue_in`.

## Test plan
- **Basic word:** send 8'h80 LSB first (7 zeros then a 1; strobes 10 cycles high, 10 low). Pulse enqueue with ack held high. Expect `data_out=8'h80`, `data_valid_out` high exactly 1 cycle, then `status_out=1`.
- **Delayed ack:** complete 8'hA5 and enqueue. Hold `data_ack_in=0` for 50 cycles, then raise it. Expect `data_valid_out` high with 8'hA5 stable for all 50 cycles, then low 1 cycle after the ack.
- **Misuse:**
  - An enqueue edge after 3 bits gives a `drop_out` pulse. The next 5 bits still complete the word.
  - A 9th write edge in FULL gives a `drop_out` pulse and `data_out` unchanged.
- **Reset:** assert `rst` for 3 cycles after 4 bits of 8'hFF, with `write_in` held high through release. Expect no spurious capture, `cnt=0`, and `status_out=1`. Sending 8'h01 afterwards yields 8'h01.
- **Back-to-back:** send 8'h80 through 8'h87 consecutively, ack each 5 cycles after valid. Expect the 8 words in order with zero `drop_out` pulses. Repeat with `SERIAL_DESER_SYNC_EN` defined and check every latency is +2.

Source files
------------

// File: rtl/serial_deser_pkg.sv
// Shared types and defaults for the serial deserializer that feeds the byte queue.
package serial_deser_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    FULL,
    HANDOFF
  } deser_state_t;

  localparam int DATA_W_DEFAULT = 8;

endpackage

// File: rtl/serial_deserializer_edge_rise.sv
// Rising-edge detector for a level strobe; the history flop resets high so a
// strobe already asserted when reset releases is not mistaken for a new edge.
module edge_rise
  import serial_deser_pkg::*;
(
  input  logic clock_1MHz,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic r_prev;

  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= in;
    end
  end

  assign rise = in & ~r_prev;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-word collector (LSB first) with a valid/ack handoff to the byte queue.
// Build option SERIAL_DESER_SYNC_EN adds 2-flop synchronizers on data_in, write_in, enqueue_in.
module serial_deserializer
  import serial_deser_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clock_1MHz,
  input  logic              rst,
  input  logic              data_in,
  input  logic              write_in,
  input  logic              enqueue_in,
  input  logic              data_ack_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid_out,
  output logic              status_out,
  output logic              drop_out
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic w_data;
  logic w_write;
  logic w_enqueue;

`ifdef SERIAL_DESER_SYNC_EN
  logic [1:0] r_data_sync;
  logic [1:0] r_write_sync;
  logic [1:0] r_enq_sync;

  // data_in rides the same two-flop delay as write_in so bit alignment holds
  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      r_data_sync  <= 2'b00;
      r_write_sync <= 2'b00;
      r_enq_sync   <= 2'b00;
    end else begin
      r_data_sync  <= {r_data_sync[0], data_in};
      r_write_sync <= {r_write_sync[0], write_in};
      r_enq_sync   <= {r_enq_sync[0], enqueue_in};
    end
  end

  assign w_data    = r_data_sync[1];
  assign w_write   = r_write_sync[1];
  assign w_enqueue = r_enq_sync[1];
`else
  assign w_data    = data_in;
  assign w_write   = write_in;
  assign w_enqueue = enqueue_in;
`endif

  logic w_write_rise;
  logic w_enq_rise;

  edge_rise u_write_edge (
    .clock_1MHz (clock_1MHz),
    .rst        (rst),
    .in         (w_write),
    .rise       (w_write_rise)
  );

  edge_rise u_enq_edge (
    .clock_1MHz (clock_1MHz),
    .rst        (rst),
    .in         (w_enqueue),
    .rise       (w_enq_rise)
  );

  deser_state_t      r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] w_next_shreg;
  logic              w_last_bit;

  // Shift register image with the incoming bit placed, so a completing word
  // can be copied to data_out in the same cycle as its final bit lands.
  always_comb begin
    w_next_shreg = r_shreg;
    for (int i = 0; i < DATA_W; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_next_shreg[i] = w_data;
      end
    end
  end

  assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      r_state        <= COLLECT;
      r_cnt          <= '0;
      r_shreg        <= '0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      status_out     <= 1'b1;
      drop_out       <= 1'b0;
    end else begin
      drop_out <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (w_write_rise) begin
            r_shreg <= w_next_shreg;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last_bit) begin
              r_state    <= FULL;
              data_out   <= w_next_shreg;
              status_out <= 1'b0;
            end
          end
          if (w_enq_rise) begin
            drop_out <= 1'b1;
          end
        end
        FULL: begin
          if (w_enq_rise) begin
            r_state        <= HANDOFF;
            data_valid_out <= 1'b1;
          end
          if (w_write_rise) begin
            drop_out <= 1'b1;
          end
        end
        HANDOFF: begin
          if (data_ack_in) begin
            r_state        <= COLLECT;
            data_valid_out <= 1'b0;
            status_out     <= 1'b1;
            r_cnt          <= '0;
            r_shreg        <= '0;
          end
          if (w_write_rise || w_enq_rise) begin
            drop_out <= 1'b1;
          end
        end
        default: begin
          r_state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer: scoreboard of handed-off words
// plus per-scenario latency, drop and reset checks.
module tb_serial_deserializer;

`ifdef SERIAL_DESER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in;
  logic       write_in;
  logic       enqueue_in;
  logic       data_ack_in;
  logic [7:0] data_out;
  logic       data_valid_out;
  logic       status_out;
  logic       drop_out;

  int         checks = 0;
  int         errors = 0;
  int         drop_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_word;

  serial_deserializer #(.DATA_W(8)) dut (
    .clock_1MHz     (clk),
    .rst            (rst),
    .data_in        (data_in),
    .write_in       (write_in),
    .enqueue_in     (enqueue_in),
    .data_ack_in    (data_ack_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .status_out     (status_out),
    .drop_out       (drop_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Scoreboard: a handshake completes at the next rising edge whenever valid and ack are both high.
  always @(negedge clk) begin
    if (drop_out === 1'b1) drop_cnt++;
    if (data_valid_out === 1'b1 && data_ack_in === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL handoff_unexpected: got %h, expected no word", data_out);
      end else begin
        exp_word = exp_q.pop_front();
        if (data_out !== exp_word) begin
          errors++;
          $display("FAIL handoff_word: got %h, expected %h", data_out, exp_word);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int hi, input int lo);
    data_in  = b;
    write_in = 1'b1;
    repeat (hi) tick();
    write_in = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic send_word(input logic [7:0] w, input int hi, input int lo);
    for (int i = 0; i < 8; i++) send_bit(w[i], hi, lo);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_in = 1'b0;
    write_in = 1'b0;
    enqueue_in = 1'b0;
    data_ack_in = 1'b0;
    repeat (3) tick();
    checks++;
    if (data_out !== 8'h00 || data_valid_out !== 1'b0 || status_out !== 1'b1 || drop_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h valid=%b status=%b drop=%b, expected 00/0/1/0",
               data_out, data_valid_out, status_out, drop_out);
    end
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (status_out !== 1'b1 || data_valid_out !== 1'b0 || drop_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got valid=%b status=%b drop=%b, expected 0/1/0",
               data_valid_out, status_out, drop_out);
    end
  endtask

  task automatic test_basic();
    data_ack_in = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(1'b0, 10, 10);
    data_in  = 1'b1;
    write_in = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      if (i == LAT - 1) begin
        checks++;
        if (status_out !== 1'b1) begin
          errors++;
          $display("FAIL basic_full_early: got status=%b, expected 1", status_out);
        end
      end
    end
    checks++;
    if (status_out !== 1'b0 || data_out !== 8'h80) begin
      errors++;
      $display("FAIL basic_full: got status=%b data=%h, expected 0/80", status_out, data_out);
    end
    repeat (10 - LAT) tick();
    write_in = 1'b0;
    repeat (10) tick();
    exp_q.push_back(8'h80);
    enqueue_in = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      if (i == LAT - 1) begin
        checks++;
        if (data_valid_out !== 1'b0) begin
          errors++;
          $display("FAIL basic_valid_early: got valid=%b, expected 0", data_valid_out);
        end
      end
    end
    checks++;
    if (data_valid_out !== 1'b1 || data_out !== 8'h80) begin
      errors++;
      $display("FAIL basic_valid: got valid=%b data=%h, expected 1/80", data_valid_out, data_out);
    end
    tick();
    checks++;
    if (data_valid_out !== 1'b0 || status_out !== 1'b1) begin
      errors++;
      $display("FAIL basic_after_ack: got valid=%b status=%b, expected 0/1", data_valid_out, status_out);
    end
    enqueue_in = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_delayed_ack();
    int bad = 0;
    data_ack_in = 1'b0;
    send_word(8'hA5, 10, 10);
    exp_q.push_back(8'hA5);
    enqueue_in = 1'b1;
    repeat (LAT) tick();
    for (int i = 0; i < 50; i++) begin
      if (i == 3) enqueue_in = 1'b0;
      if (data_valid_out !== 1'b1 || data_out !== 8'hA5) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL delayed_hold: got %0d cycles without valid/A5, expected 0", bad);
    end
    data_ack_in = 1'b1;
    tick();
    checks++;
    if (data_valid_out !== 1'b0 || status_out !== 1'b1) begin
      errors++;
      $display("FAIL delayed_release: got valid=%b status=%b, expected 0/1", data_valid_out, status_out);
    end
    repeat (4) tick();
  endtask

  task automatic test_misuse();
    logic [7:0] w = 8'h3C;
    int drops0 = drop_cnt;
    data_ack_in = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(w[i], 2, 2);
    enqueue_in = 1'b1;
    repeat (LAT) tick();
    checks++;
    if (drop_out !== 1'b1) begin
      errors++;
      $display("FAIL misuse_enq_drop: got drop=%b, expected 1", drop_out);
    end
    tick();
    checks++;
    if (drop_out !== 1'b0 || status_out !== 1'b1) begin
      errors++;
      $display("FAIL misuse_enq_pulse: got drop=%b status=%b, expected 0/1", drop_out, status_out);
    end
    enqueue_in = 1'b0;
    repeat (2) tick();
    for (int i = 3; i < 8; i++) send_bit(w[i], 2, 2);
    checks++;
    if (status_out !== 1'b0 || data_out !== w) begin
      errors++;
      $display("FAIL misuse_partial_kept: got status=%b data=%h, expected 0/%h", status_out, data_out, w);
    end
    data_in  = 1'b1;
    write_in = 1'b1;
    repeat (LAT) tick();
    checks++;
    if (drop_out !== 1'b1) begin
      errors++;
      $display("FAIL misuse_write_drop: got drop=%b, expected 1", drop_out);
    end
    tick();
    checks++;
    if (drop_out !== 1'b0 || data_out !== w || status_out !== 1'b0) begin
      errors++;
      $display("FAIL misuse_full_hold: got drop=%b data=%h status=%b, expected 0/%h/0",
               drop_out, data_out, status_out, w);
    end
    write_in = 1'b0;
    repeat (2) tick();
    checks++;
    if (drop_cnt - drops0 != 2) begin
      errors++;
      $display("FAIL misuse_drop_count: got %0d pulses, expected 2", drop_cnt - drops0);
    end
    exp_q.push_back(w);
    enqueue_in = 1'b1;
    repeat (LAT + 2) tick();
    enqueue_in = 1'b0;
    repeat (2) tick();
    checks++;
    if (data_valid_out !== 1'b0 || status_out !== 1'b1) begin
      errors++;
      $display("FAIL misuse_handoff: got valid=%b status=%b, expected 0/1", data_valid_out, status_out);
    end
  endtask

  task automatic test_reset_mid();
    data_ack_in = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(1'b1, 2, 2);
    data_in  = 1'b1;
    write_in = 1'b1;
    repeat (LAT) tick();
    rst = 1'b1;
    repeat (3) tick();
`ifdef SERIAL_DESER_SYNC_EN
    write_in = 1'b0;
`endif
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (dut.r_cnt !== '0 || dut.r_shreg !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_state: got cnt=%0d shreg=%h, expected 0/00", dut.r_cnt, dut.r_shreg);
    end
    checks++;
    if (status_out !== 1'b1 || data_valid_out !== 1'b0 || data_out !== 8'h00 || drop_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got status=%b valid=%b data=%h drop=%b, expected 1/0/00/0",
               status_out, data_valid_out, data_out, drop_out);
    end
    write_in = 1'b0;
    repeat (2) tick();
    send_word(8'h01, 2, 2);
    checks++;
    if (data_out !== 8'h01 || status_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_word: got data=%h status=%b, expected 01/0", data_out, status_out);
    end
    exp_q.push_back(8'h01);
    enqueue_in = 1'b1;
    repeat (LAT + 2) tick();
    enqueue_in = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    int drops0 = drop_cnt;
    int t;
    data_ack_in = 1'b0;
    for (int n = 0; n < 8; n++) begin
      send_word(8'h80 + 8'(n), 2, 2);
      exp_q.push_back(8'h80 + 8'(n));
      enqueue_in = 1'b1;
      t = 0;
      while (data_valid_out !== 1'b1 && t < 20) begin
        tick();
        t++;
      end
      checks++;
      if (t >= 20) begin
        errors++;
        $display("FAIL b2b_valid_timeout: word %0d, got valid=%b, expected 1 within 20 cycles", n, data_valid_out);
      end
      enqueue_in = 1'b0;
      repeat (5) tick();
      checks++;
      if (data_valid_out !== 1'b1 || data_out !== 8'h80 + 8'(n)) begin
        errors++;
        $display("FAIL b2b_hold: word %0d got valid=%b data=%h, expected 1/%h", n, data_valid_out, data_out, 8'h80 + 8'(n));
      end
      data_ack_in = 1'b1;
      tick();
      data_ack_in = 1'b0;
      checks++;
      if (data_valid_out !== 1'b0 || status_out !== 1'b1) begin
        errors++;
        $display("FAIL b2b_release: word %0d got valid=%b status=%b, expected 0/1", n, data_valid_out, status_out);
      end
    end
    checks++;
    if (drop_cnt != drops0) begin
      errors++;
      $display("FAIL b2b_drops: got %0d pulses, expected 0", drop_cnt - drops0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delayed_ack();
    test_misuse();
    test_reset_mid();
    test_back_to_back();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d words pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
